// File: rtl/wb_stage_multi.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_multi
// Description : Multi-lane writeback stage. Captures a bundle of up to LANES
//               in-order instructions (lane 0 oldest) and retires them to the
//               register file, the CSR/exception unit and a 64-bit retire
//               counter. CSR writes and exceptions are serialised to one per
//               cycle by committing the bundle in slices; an exception
//               squashes every younger lane of its bundle.
// Ports       : clk, rstn (async active-low)
//               mw_*       bundle from the memory stage, w_allowin handshake
//               ex_en      flush from the CSR unit
//               rf_*       per-lane register file write ports
//               csr_*      single CSR write port
//               ex_*       exception report
//               retire_cnt count of retired non-excepting lanes
//               debug_wb_* trace ports (active only with WB_DEBUG_EN)
// Config      : define WB_DEBUG_EN to drive the debug_wb_* trace ports;
//               otherwise they are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage_multi #(
    parameter int          LANES          = 2,
    parameter int          DATA_W         = 32,
    // Reset value of the retire counter; a platform may start from a base.
    parameter logic [63:0] RETIRE_RST_VAL = 64'd0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    mw_valid,
    input  logic [LANES-1:0]        mw_lane_valid,
    output logic                    w_allowin,
    input  logic [32*LANES-1:0]     mw_pc,
    input  logic [32*LANES-1:0]     mw_vaddr,
    input  logic [DATA_W*LANES-1:0] mw_result,
    input  logic [LANES-1:0]        mw_gr_we,
    input  logic [5*LANES-1:0]      mw_dest,
    input  logic [LANES-1:0]        mw_ex,
    input  logic [8*LANES-1:0]      mw_ecode,
    input  logic [9*LANES-1:0]      mw_esubcode,
    input  logic [LANES-1:0]        mw_csr_we,
    input  logic [14*LANES-1:0]     mw_csr_addr,
    input  logic [32*LANES-1:0]     mw_csr_wmask,
    input  logic [32*LANES-1:0]     mw_csr_wdata,
    input  logic                    ex_en,
    output logic [LANES-1:0]        rf_we,
    output logic [5*LANES-1:0]      rf_waddr,
    output logic [DATA_W*LANES-1:0] rf_wdata,
    output logic                    csr_we,
    output logic [13:0]             csr_addr,
    output logic [31:0]             csr_wmask,
    output logic [31:0]             csr_wdata,
    output logic                    ex_valid,
    output logic [7:0]              ex_ecode,
    output logic [8:0]              ex_esubcode,
    output logic [31:0]             ex_pc,
    output logic [31:0]             ex_vaddr,
    output logic [63:0]             retire_cnt,
    output logic [32*LANES-1:0]     debug_wb_pc,
    output logic [4*LANES-1:0]      debug_wb_rf_we,
    output logic [5*LANES-1:0]      debug_wb_rf_wnum,
    output logic [DATA_W*LANES-1:0] debug_wb_rf_wdata
);

    // Captured bundle
    logic                    r_wb_valid;
    logic [LANES-1:0]        r_pending;
    logic [32*LANES-1:0]     r_pc;
    logic [32*LANES-1:0]     r_vaddr;
    logic [DATA_W*LANES-1:0] r_result;
    logic [LANES-1:0]        r_gr_we;
    logic [5*LANES-1:0]      r_dest;
    logic [LANES-1:0]        r_ex;
    logic [8*LANES-1:0]      r_ecode;
    logic [9*LANES-1:0]      r_esubcode;
    logic [LANES-1:0]        r_csr_we;
    logic [14*LANES-1:0]     r_csr_addr;
    logic [32*LANES-1:0]     r_csr_wmask;
    logic [32*LANES-1:0]     r_csr_wdata;
    logic [63:0]             r_retire_cnt;

    logic [LANES-1:0]        w_slice;
    logic [LANES-1:0]        w_ser_oh;
    logic                    w_found;
    logic                    w_ser_ex;
    logic [LANES-1:0]        w_commit;
    logic [LANES-1:0]        w_rf_pre;
    logic [LANES-1:0]        w_rf_we;
    logic                    w_last_slice;
    logic [2:0]              w_retire_inc;

    // Slice = pending lanes up to and including the oldest pending lane that
    // needs the serialised CSR/exception port.
    always_comb begin
        w_slice  = '0;
        w_ser_oh = '0;
        w_found  = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (!w_found) begin
                w_slice[l] = r_pending[l];
                if (r_pending[l] && (r_csr_we[l] || r_ex[l])) begin
                    w_ser_oh[l] = 1'b1;
                    w_found     = 1'b1;
                end
            end
        end
    end

    assign w_ser_ex     = |(w_ser_oh & r_ex);
    // Only the serialiser can carry an exception inside a slice.
    assign w_commit     = r_wb_valid ? (w_slice & ~(w_ser_oh & r_ex)) : '0;
    assign w_last_slice = w_ser_ex || ((r_pending & ~w_slice) == '0);
    assign w_allowin    = !r_wb_valid || w_last_slice;

    always_comb begin
        w_rf_pre = '0;
        for (int l = 0; l < LANES; l++) begin
            w_rf_pre[l] = w_commit[l] && r_gr_we[l] && !r_ex[l]
                          && (r_dest[l*5 +: 5] != 5'd0);
        end
    end

    // A younger lane writing the same register in this slice wins.
    always_comb begin
        w_rf_we = w_rf_pre;
        for (int l = 0; l < LANES; l++) begin
            for (int h = l + 1; h < LANES; h++) begin
                if (w_rf_pre[h] && (r_dest[h*5 +: 5] == r_dest[l*5 +: 5])) begin
                    w_rf_we[l] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_retire_inc = '0;
        for (int l = 0; l < LANES; l++) begin
            w_retire_inc = w_retire_inc + {2'd0, w_commit[l]};
        end
    end

    // CSR / exception ports are driven from the serialiser lane; zero otherwise.
    always_comb begin
        csr_addr    = '0;
        csr_wmask   = '0;
        csr_wdata   = '0;
        ex_ecode    = '0;
        ex_esubcode = '0;
        ex_pc       = '0;
        ex_vaddr    = '0;
        for (int l = 0; l < LANES; l++) begin
            if (w_ser_oh[l] && !r_ex[l]) begin
                csr_addr  = r_csr_addr[l*14 +: 14];
                csr_wmask = r_csr_wmask[l*32 +: 32];
                csr_wdata = r_csr_wdata[l*32 +: 32];
            end
            if (w_ser_oh[l] && r_ex[l]) begin
                ex_ecode    = r_ecode[l*8 +: 8];
                ex_esubcode = r_esubcode[l*9 +: 9];
                ex_pc       = r_pc[l*32 +: 32];
                ex_vaddr    = r_vaddr[l*32 +: 32];
            end
        end
    end

    assign csr_we     = r_wb_valid && (|w_ser_oh) && !w_ser_ex;
    assign ex_valid   = r_wb_valid && w_ser_ex;
    assign rf_we      = w_rf_we;
    assign rf_waddr   = r_dest;
    assign rf_wdata   = r_result;
    assign retire_cnt = r_retire_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wb_valid   <= 1'b0;
            r_pending    <= '0;
            r_pc         <= '0;
            r_vaddr      <= '0;
            r_result     <= '0;
            r_gr_we      <= '0;
            r_dest       <= '0;
            r_ex         <= '0;
            r_ecode      <= '0;
            r_esubcode   <= '0;
            r_csr_we     <= '0;
            r_csr_addr   <= '0;
            r_csr_wmask  <= '0;
            r_csr_wdata  <= '0;
            r_retire_cnt <= RETIRE_RST_VAL;
        end else begin
            // The current slice commits even when a flush arrives.
            r_retire_cnt <= r_retire_cnt + {61'd0, w_retire_inc};
            if (ex_en) begin
                r_wb_valid <= 1'b0;
                r_pending  <= '0;
            end else if (mw_valid && w_allowin) begin
                r_wb_valid  <= |mw_lane_valid;
                r_pending   <= mw_lane_valid;
                r_pc        <= mw_pc;
                r_vaddr     <= mw_vaddr;
                r_result    <= mw_result;
                r_gr_we     <= mw_gr_we;
                r_dest      <= mw_dest;
                r_ex        <= mw_ex;
                r_ecode     <= mw_ecode;
                r_esubcode  <= mw_esubcode;
                r_csr_we    <= mw_csr_we;
                r_csr_addr  <= mw_csr_addr;
                r_csr_wmask <= mw_csr_wmask;
                r_csr_wdata <= mw_csr_wdata;
            end else if (r_wb_valid) begin
                r_pending <= w_ser_ex ? '0 : (r_pending & ~w_slice);
                if (w_last_slice) begin
                    r_wb_valid <= 1'b0;
                end
            end
        end
    end

`ifdef WB_DEBUG_EN
    generate
        for (genvar g = 0; g < LANES; g++) begin : g_dbg
            assign debug_wb_pc[g*32 +: 32]  = r_pc[g*32 +: 32];
            assign debug_wb_rf_we[g*4 +: 4] = {4{w_rf_we[g]}};
        end
    endgenerate
    assign debug_wb_rf_wnum  = r_dest;
    assign debug_wb_rf_wdata = r_result;
`else
    assign debug_wb_pc       = '0;
    assign debug_wb_rf_we    = '0;
    assign debug_wb_rf_wnum  = '0;
    assign debug_wb_rf_wdata = '0;
`endif

endmodule
`default_nettype wire
